alu_xfer_sequencer: RTL and testbench
=====================================

Name: alu_xfer_sequencer

Overview:
- Single-bus control unit that sequences one ALU register-to-register operation: source A → Y, source B → ALU → Z latch, Z → destination register.
- Generates all one-hot register drive/load strobes, plus Y_in, Z_in, Z_out and the ALU opcode.
- Guarantees at most one bus driver per cycle.
- Sits between instruction decode and the register file / Y / Z datapath of the 16-bit core.

Parameters:
- NUM_REGS, 8, number of general registers; sets strobe vector width.
- SEL_W, 3, register select width; must satisfy 2**SEL_W >= NUM_REGS.
- OP_W, 4, ALU opcode width.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  command valid; sampled only when accepted.
- unary  in  1  operation uses B only; skip the Y load step.
- src_a  in  SEL_W  register loaded into Y.
- src_b  in  SEL_W  register driven to bus during execute.
- dst  in  SEL_W  destination register.
- alu_op  in  OP_W  ALU operation code.
- hold  in  1  freeze sequencer, e.g. for memory wait.
- reg_out_en  out  NUM_REGS  one-hot register bus-drive strobes.
- reg_in_en  out  NUM_REGS  one-hot register load strobes.
- Y_in  out  1  load Y from bus.
- Z_in  out  1  Z latches ALU result.
- Z_out  out  1  Z drives bus.
- alu_op_out  out  OP_W  opcode presented to ALU.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the WRITE cycle.

Behaviour:
- Reset (synchronous, active-high): state = IDLE; command registers cleared; every output 0, including alu_op_out = 0.
- Reset asserted mid-operation: the next cycle is IDLE with all strobes 0. A partial register write is never completed.
- States and transitions:
  - IDLE → LOAD_Y on start & !hold & !unary.
  - IDLE → EXEC on start & !hold & unary.
  - LOAD_Y → EXEC.
  - EXEC → WRITE.
  - WRITE → IDLE.
- Command capture: src_a, src_b, dst, alu_op and unary are registered when start is accepted in IDLE.
  - Inputs are don't-care at all other times.
  - start is ignored while busy, with no queuing.
- Outputs are Moore-decoded from state and the captured command only; there is no combinational path from start to any strobe.
- Per-state outputs:
  - IDLE: all strobes 0.
  - LOAD_Y: reg_out_en[src_a] = 1, Y_in = 1.
  - EXEC: reg_out_en[src_b] = 1, Z_in = 1, alu_op_out = captured op. alu_op_out is 0 in every other state.
  - WRITE: Z_out = 1, reg_in_en[dst] = 1, done = 1.
- Latency from start cycle t:
  - Binary op: LOAD_Y t+1, EXEC t+2, WRITE t+3, IDLE t+4.
  - Unary op: EXEC t+1, WRITE t+2.
- hold: when high in a non-IDLE state, the state and all outputs are held for that cycle; done stays high for as many cycles as WRITE is held.
- Select value >= NUM_REGS: that strobe vector is all 0; the sequence still runs, and Y_in, Z_in, Z_out behave normally.
- src == dst, or src_a == src_b: legal, with no special handling.
- Invariant: popcount(reg_out_en) + Z_out <= 1 in every cycle.

Optional Feature:
- Macro SEQ_BACK_TO_BACK_EN.
- Defined: start is also accepted in the WRITE cycle (when !hold). The command is captured and the state goes directly to LOAD_Y, or to EXEC if unary, with no IDLE bubble. busy stays high across the boundary.
- Undefined: start is accepted only in IDLE, giving a minimum 4-cycle spacing between binary ops.

Decomposition:
- Package alu_seq_pkg:
  - State enum: IDLE = 2'd0, LOAD_Y = 2'd1, EXEC = 2'd2, WRITE = 2'd3.
  - OP_W default.
  - Constant ALU_OP_NOP = 0.
- Sub-module reg_sel_decoder (SEL_W → NUM_REGS one-hot with enable and out-of-range zeroing), instantiated twice: once for out strobes, once for in strobes.

Test Plan:
1. Reset held 2 cycles, then released with start = 0 → all outputs 0, busy = 0.
2. Binary op: start with src_a = 1, src_b = 2, dst = 3, alu_op = 4'h5 → reg_out_en = 8'h02 with Y_in at t+1; reg_out_en = 8'h04, Z_in, alu_op_out = 5 at t+2; Z_out, reg_in_en = 8'h08, done at t+3; IDLE at t+4.
3. Unary op (unary = 1, src_b = 7, dst = 0) → EXEC at t+1 with reg_out_en = 8'h80; WRITE at t+2 with reg_in_en = 8'h01; Y_in never asserted.
4. hold = 1 for 3 cycles during EXEC → Z_in and reg_out_en held 4 cycles total; WRITE follows; start pulses during busy are ignored.
5. Reset asserted during EXEC → next cycle all strobes 0, busy = 0; reg_in_en never asserted for that command.
6. SEQ_BACK_TO_BACK_EN defined, second start in WRITE → LOAD_Y on the very next cycle, busy continuously high. Undefined → same stimulus is ignored and the state returns to IDLE.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// rtl/alu_seq_pkg.sv - shared state encoding and constants for the ALU transfer sequencer
package alu_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_Y = 2'd1,
        EXEC   = 2'd2,
        WRITE  = 2'd3
    } seq_state_t;

    localparam int OP_W_DEFAULT = 4;
    localparam int ALU_OP_NOP   = 0;

endpackage

// File: rtl/reg_sel_decoder.sv
// rtl/reg_sel_decoder.sv - register select to one-hot strobe decoder with enable
module reg_sel_decoder #(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3
) (
    input  logic                en,
    input  logic [SEL_W-1:0]    sel,
    output logic [NUM_REGS-1:0] onehot
);

    // Selects at or beyond NUM_REGS match no index, so the vector stays zero.
    always_comb begin
        onehot = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            onehot[i] = en && (sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/alu_xfer_sequencer.sv
// rtl/alu_xfer_sequencer.sv - single-bus A->Y, B->ALU->Z, Z->dst sequencer; option SEQ_BACK_TO_BACK_EN
module alu_xfer_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NUM_REGS = 8,
    parameter int SEL_W    = 3,
    parameter int OP_W     = OP_W_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                unary,
    input  logic [SEL_W-1:0]    src_a,
    input  logic [SEL_W-1:0]    src_b,
    input  logic [SEL_W-1:0]    dst,
    input  logic [OP_W-1:0]     alu_op,
    input  logic                hold,
    output logic [NUM_REGS-1:0] reg_out_en,
    output logic [NUM_REGS-1:0] reg_in_en,
    output logic                Y_in,
    output logic                Z_in,
    output logic                Z_out,
    output logic [OP_W-1:0]     alu_op_out,
    output logic                busy,
    output logic                done
);

    seq_state_t       state, state_nxt;
    logic [SEL_W-1:0] src_a_q, src_b_q, dst_q;
    logic [OP_W-1:0]  op_q;
    logic             unary_q;
    logic             accept;
    logic             out_drive;
    logic [SEL_W-1:0] out_sel;

`ifdef SEQ_BACK_TO_BACK_EN
    assign accept = start && !hold && (state == IDLE || state == WRITE);
`else
    assign accept = start && !hold && (state == IDLE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            op_q    <= '0;
            unary_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src_a_q <= src_a;
                src_b_q <= src_b;
                dst_q   <= dst;
                op_q    <= alu_op;
                unary_q <= unary;
            end
        end
    end

    // hold freezes every non-IDLE state; in IDLE it simply blocks acceptance.
    always_comb begin
        state_nxt = state;
        if (!hold) begin
            case (state)
                IDLE:    if (accept) state_nxt = unary ? EXEC : LOAD_Y;
                LOAD_Y:  state_nxt = EXEC;
                EXEC:    state_nxt = WRITE;
                WRITE:   state_nxt = accept ? (unary ? EXEC : LOAD_Y) : IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_drive  = 1'b0;
        out_sel    = src_b_q;
        Y_in       = 1'b0;
        Z_in       = 1'b0;
        Z_out      = 1'b0;
        alu_op_out = OP_W'(ALU_OP_NOP);
        busy       = (state != IDLE);
        done       = 1'b0;
        case (state)
            LOAD_Y: begin
                out_drive = !unary_q;
                out_sel   = src_a_q;
                Y_in      = !unary_q;
            end
            EXEC: begin
                out_drive  = 1'b1;
                Z_in       = 1'b1;
                alu_op_out = op_q;
            end
            WRITE: begin
                Z_out = 1'b1;
                done  = 1'b1;
            end
            default: ;
        endcase
    end

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_out_dec (
        .en     (out_drive),
        .sel    (out_sel),
        .onehot (reg_out_en)
    );

    reg_sel_decoder #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W)) u_in_dec (
        .en     (state == WRITE),
        .sel    (dst_q),
        .onehot (reg_in_en)
    );

endmodule

// File: tb/tb_alu_xfer_sequencer.sv
// tb/tb_alu_xfer_sequencer.sv - randomized scoreboard bench for alu_xfer_sequencer
module tb_alu_xfer_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       unary = 1'b0;
    logic       hold = 1'b0;
    logic [2:0] src_a = '0, src_b = '0, dst = '0;
    logic [3:0] alu_op = '0;

    logic [7:0] oe_a, ie_a;
    logic       y_a, zi_a, zo_a, busy_a, done_a;
    logic [3:0] op_a;
    logic [4:0] oe_b, ie_b;
    logic       y_b, zi_b, zo_b, busy_b, done_b;
    logic [3:0] op_b;

    always #5 clk = ~clk;

    alu_xfer_sequencer #(.NUM_REGS(8), .SEL_W(3), .OP_W(4)) dut_a (
        .clk(clk), .reset(reset), .start(start), .unary(unary),
        .src_a(src_a), .src_b(src_b), .dst(dst), .alu_op(alu_op), .hold(hold),
        .reg_out_en(oe_a), .reg_in_en(ie_a), .Y_in(y_a), .Z_in(zi_a), .Z_out(zo_a),
        .alu_op_out(op_a), .busy(busy_a), .done(done_a)
    );

    alu_xfer_sequencer #(.NUM_REGS(5), .SEL_W(3), .OP_W(4)) dut_b (
        .clk(clk), .reset(reset), .start(start), .unary(unary),
        .src_a(src_a), .src_b(src_b), .dst(dst), .alu_op(alu_op), .hold(hold),
        .reg_out_en(oe_b), .reg_in_en(ie_b), .Y_in(y_b), .Z_in(zi_b), .Z_out(zo_b),
        .alu_op_out(op_b), .busy(busy_b), .done(done_b)
    );

    // A command is a list of bus phases: 1 = A to Y, 2 = B through ALU to Z, 3 = Z to dst.
    typedef struct {
        int         kind;
        logic [2:0] a, b, d;
        logic [3:0] op;
    } phase_t;

    phase_t      ph_q[$];
    logic [24:0] exp_a_q[$];
    logic [24:0] exp_b_q[$];
    int          checks = 0;
    int          errors = 0;
    bit          b2b;

    function automatic logic [7:0] strobe(logic [2:0] s, int n);
        logic [7:0] v;
        v = 8'h00;
        if (int'(s) < n) v[s] = 1'b1;
        return v;
    endfunction

    function automatic logic [24:0] expect_vec(bit act, phase_t p, int n);
        logic [7:0] oe, ie;
        logic       y, zi, zo;
        logic [3:0] op;
        oe = 8'h00; ie = 8'h00; y = 1'b0; zi = 1'b0; zo = 1'b0; op = 4'h0;
        if (act) begin
            case (p.kind)
                1: begin oe = strobe(p.a, n); y = 1'b1; end
                2: begin oe = strobe(p.b, n); zi = 1'b1; op = p.op; end
                3: begin ie = strobe(p.d, n); zo = 1'b1; end
                default: ;
            endcase
        end
        return {oe, ie, y, zi, zo, op, act, act && (p.kind == 3)};
    endfunction

    always @(posedge clk) begin : model
        bit     was_idle, in_write;
        phase_t p, cur;
        if (reset) begin
            ph_q.delete();
        end else begin
            was_idle = (ph_q.size() == 0);
            in_write = (ph_q.size() == 1);
            if (!was_idle && !hold) void'(ph_q.pop_front());
            if (start && !hold && (was_idle || (b2b && in_write))) begin
                p.a = src_a; p.b = src_b; p.d = dst; p.op = alu_op;
                if (!unary) begin p.kind = 1; ph_q.push_back(p); end
                p.kind = 2; ph_q.push_back(p);
                p.kind = 3; ph_q.push_back(p);
            end
        end
        cur.kind = 0; cur.a = '0; cur.b = '0; cur.d = '0; cur.op = '0;
        if (ph_q.size() > 0) cur = ph_q[0];
        exp_a_q.push_back(expect_vec(ph_q.size() > 0, cur, 8));
        exp_b_q.push_back(expect_vec(ph_q.size() > 0, cur, 5));
    end

    task automatic check(string name, logic [24:0] act, logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [24:0] e;
        if (exp_a_q.size() > 0) begin
            e = exp_a_q.pop_front();
            check("outputs_r8", {oe_a, ie_a, y_a, zi_a, zo_a, op_a, busy_a, done_a}, e);
            checks++;
            if ($countones(oe_a) + int'(zo_a) > 1) begin
                errors++;
                $display("FAIL bus_single_driver at %0t: reg_out_en=%h Z_out=%b", $time, oe_a, zo_a);
            end
        end
        if (exp_b_q.size() > 0) begin
            e = exp_b_q.pop_front();
            check("outputs_r5", {3'b000, oe_b, 3'b000, ie_b, y_b, zi_b, zo_b, op_b, busy_b, done_b}, e);
        end
    end

    task automatic cyc(bit s, bit u, int a, int b, int d, int op, bit h);
        start = s; unary = u; hold = h;
        src_a = 3'(a); src_b = 3'(b); dst = 3'(d); alu_op = 4'(op);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
`ifdef SEQ_BACK_TO_BACK_EN
        b2b = 1'b1;
`else
        b2b = 1'b0;
`endif
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        idle(3);
        cyc(1, 0, 1, 2, 3, 5, 0);
        idle(5);
        cyc(1, 1, 0, 7, 0, 9, 0);
        idle(4);
        cyc(1, 0, 4, 6, 2, 10, 0);
        idle(1);
        repeat (3) cyc(1, 0, 7, 7, 7, 3, 1);
        idle(5);
        cyc(1, 0, 5, 5, 5, 3, 0);
        idle(1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(3);
        cyc(1, 0, 1, 2, 3, 4, 0);
        idle(2);
        cyc(1, 1, 6, 3, 7, 15, 0);
        idle(5);
        cyc(1, 0, 6, 7, 5, 2, 0);
        idle(5);
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
                $urandom_range(0, 15), $urandom_range(0, 3) == 0);
        end
        reset = 1'b0;
        idle(6);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
